// File: rtl/aes_pkg.sv
// Shared AES helpers for the decrypt datapath.
// Holds the state/column widths, the GF(2^8) constant multipliers used by
// InvMixColumns (reduction polynomial 0x11B), and the inv_mix_columns_seq
// FSM state type.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IMC_IDLE,
    IMC_BUSY,
    IMC_DONE
  } imc_state_e;

  // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for inv_mix_columns_seq.
//   in_valid/in_ready/in    : upstream state transfer (master -> slave)
//   out_valid/out_ready/out : result transfer (slave -> master)
// The slave modport is the engine side; master is the surrounding datapath.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out;

  modport master (
    output in_valid,
    output in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out
  );

endinterface

// File: rtl/inv_mix_column.sv
// Single-column AES InvMixColumns, purely combinational.
//   i_col : column {s0,s1,s2,s3}, s0 in the top byte
//   o_col : transformed column in the same byte order
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] i_col,
  output logic [AES_COL_W-1:0] o_col
);

  logic [7:0] w_s0, w_s1, w_s2, w_s3;

  assign w_s0 = i_col[31:24];
  assign w_s1 = i_col[23:16];
  assign w_s2 = i_col[15:8];
  assign w_s3 = i_col[7:0];

  assign o_col[31:24] = gmul0e(w_s0) ^ gmul0b(w_s1) ^ gmul0d(w_s2) ^ gmul09(w_s3);
  assign o_col[23:16] = gmul09(w_s0) ^ gmul0e(w_s1) ^ gmul0b(w_s2) ^ gmul0d(w_s3);
  assign o_col[15:8]  = gmul0d(w_s0) ^ gmul09(w_s1) ^ gmul0e(w_s2) ^ gmul0b(w_s3);
  assign o_col[7:0]   = gmul0b(w_s0) ^ gmul0d(w_s1) ^ gmul09(w_s2) ^ gmul0e(w_s3);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of inv_mix_columns_seq_if (in/out valid-ready)
// A captured state is rewritten in place, COLS_PER_CYCLE columns per clock
// (legal: 1, 2, 4), then held on out until the downstream takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  inv_mix_columns_seq_if.slave bus
);

  localparam int unsigned N_COLS   = AES_STATE_W / AES_COL_W;
  // Step of 4 wraps to 0 in the 2-bit counter, which is harmless: with
  // four columns per cycle the first group is already the last.
  localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE % N_COLS);
  localparam logic [1:0]  COL_LAST = 2'(N_COLS - COLS_PER_CYCLE);

  imc_state_e             r_state, w_state_next;
  logic [1:0]             r_col_cnt;
  logic [AES_STATE_W-1:0] r_work, w_work_next;
  logic [AES_COL_W-1:0]   w_cols      [N_COLS];
  logic [AES_COL_W-1:0]   w_next_cols [N_COLS];
  logic [AES_COL_W-1:0]   w_mix_in    [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]   w_mix_out   [COLS_PER_CYCLE];
  logic [1:0]             w_idx       [COLS_PER_CYCLE];
  logic                   w_accept;
  logic                   w_last;

  for (genvar c = 0; c < N_COLS; c++) begin : g_unpack
    assign w_cols[c] = r_work[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_idx[k]    = r_col_cnt + 2'(k);
    assign w_mix_in[k] = w_cols[w_idx[k]];
    inv_mix_column u_col (
      .i_col (w_mix_in[k]),
      .o_col (w_mix_out[k])
    );
  end

  // Only the columns of the current group change; the rest pass through.
  always_comb begin
    for (int unsigned c = 0; c < N_COLS; c++) begin
      w_next_cols[c] = w_cols[c];
    end
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      w_next_cols[w_idx[k]] = w_mix_out[k];
    end
    w_work_next = {w_next_cols[0], w_next_cols[1], w_next_cols[2], w_next_cols[3]};
  end

  assign w_last = (r_col_cnt == COL_LAST);

  always_comb begin
    w_state_next  = r_state;
    // in_ready is gated by reset_n so it reads 0 during the reset cycle.
    bus.in_ready  = (r_state == IMC_IDLE) && reset_n;
    bus.out_valid = (r_state == IMC_DONE);
    bus.out       = r_work;
    unique case (r_state)
      IMC_IDLE: if (bus.in_valid) w_state_next = IMC_BUSY;
      IMC_BUSY: if (w_last)       w_state_next = IMC_DONE;
      IMC_DONE: if (bus.out_ready) w_state_next = IMC_IDLE;
      default:  w_state_next = IMC_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IMC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_col_cnt <= '0;
      r_work    <= '0;
    end else if (w_accept) begin
      r_col_cnt <= '0;
      r_work    <= bus.in;
    end else if (r_state == IMC_BUSY) begin
      r_col_cnt <= r_col_cnt + COL_STEP;
      r_work    <= w_work_next;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [127:0] tb_in;
  logic [2:0]   tb_in_valid;
  logic [2:0]   tb_out_ready;
  logic [2:0]   w_ir;
  logic [2:0]   w_ov;
  logic [127:0] w_out [3];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Instance 0/1/2 run with 1/2/4 columns per cycle.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq_if bus ();
    assign bus.in_valid  = tb_in_valid[g];
    assign bus.in        = tb_in;
    assign bus.out_ready = tb_out_ready[g];
    assign w_ir[g]       = bus.in_ready;
    assign w_ov[g]       = bus.out_valid;
    assign w_out[g]      = bus.out;
    inv_mix_columns_seq #(
      .COLS_PER_CYCLE ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  typedef struct {
    int           sel;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
  } vec_t;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] M_IN   = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
  localparam logic [127:0] M_OUT  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] R_IN   = 128'h9fdc589d_8e4da1bc_4d7ebdf8_d5d5d7d6;
  localparam logic [127:0] R_OUT  = 128'hf20a225c_db135345_2d26314c_d4d4d4d5;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge; ends at the negedge after the result is taken.
  task automatic run_vec(input int sel, input logic [127:0] din,
                         input logic [127:0] dout, input int lat, input string name);
    int k;
    tb_in = din;
    tb_in_valid[sel] = 1'b1;
    tb_out_ready[sel] = 1'b1;
    k = 0;
    while (!w_ir[sel] && k < 20) begin @(negedge clock); k++; end
    chk({name, " in_ready"}, 128'(w_ir[sel]), 128'd1);
    @(negedge clock);
    tb_in_valid[sel] = 1'b0;
    k = 0;
    while (!w_ov[sel] && k < 20) begin @(negedge clock); k++; end
    chk({name, " latency"}, 128'(k), 128'(lat));
    chk({name, " out"}, w_out[sel], dout);
    @(negedge clock);
    chk({name, " idle after"}, 128'({w_ov[sel], w_ir[sel]}), 128'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int acc [3];
    int na;
    bit flag;

    vecs[0] = '{0, V1_IN, V1_OUT, 4};
    vecs[1] = '{0, '0, '0, 4};
    vecs[2] = '{0, {4{32'h01010101}}, {4{32'h01010101}}, 4};
    vecs[3] = '{0, {32'hd5d5d7d6, 96'h0}, {32'hd4d4d4d5, 96'h0}, 4};
    vecs[4] = '{0, M_IN, M_OUT, 4};
    vecs[5] = '{0, R_IN, R_OUT, 4};
    vecs[6] = '{1, V1_IN, V1_OUT, 2};
    vecs[7] = '{1, M_IN, M_OUT, 2};
    vecs[8] = '{2, V1_IN, V1_OUT, 1};
    vecs[9] = '{2, R_IN, R_OUT, 1};

    reset_n = 1'b0;
    tb_in = '0;
    tb_in_valid = '0;
    tb_out_ready = '1;
    repeat (3) @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset dut%0d ready/valid", g), 128'({w_ir[g], w_ov[g]}), 128'b00);
      chk($sformatf("reset dut%0d out", g), w_out[g], '0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    chk("in_ready after reset", 128'(w_ir), 128'b111);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i].sel, vecs[i].din, vecs[i].dout, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure on instance 0.
    tb_out_ready[0] = 1'b0;
    tb_in = M_IN;
    tb_in_valid[0] = 1'b1;
    @(negedge clock);
    tb_in_valid[0] = 1'b0;
    k = 0;
    while (!w_ov[0] && k < 20) begin @(negedge clock); k++; end
    chk("bp latency", 128'(k), 128'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("bp hold %0d flags", i), 128'({w_ov[0], w_ir[0]}), 128'b10);
      chk($sformatf("bp hold %0d out", i), w_out[0], M_OUT);
    end
    tb_out_ready[0] = 1'b1;
    @(negedge clock);
    chk("bp release idle", 128'({w_ov[0], w_ir[0]}), 128'b01);

    // Reset during the second BUSY cycle.
    tb_in = V1_IN;
    tb_in_valid[0] = 1'b1;
    @(negedge clock);
    tb_in_valid[0] = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst out", w_out[0], '0);
    chk("midrst flags", 128'({w_ov[0], w_ir[0]}), 128'b00);
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst idle", 128'({w_ov[0], w_ir[0]}), 128'b01);
    flag = 1'b0;
    repeat (6) begin @(negedge clock); if (w_ov[0]) flag = 1'b1; end
    chk("midrst no stale", 128'(flag), 128'd0);
    run_vec(0, M_IN, M_OUT, 4, "post-reset");

    // Input changes and in_valid held during BUSY are ignored.
    tb_in = V1_IN;
    tb_in_valid[0] = 1'b1;
    @(negedge clock);
    tb_in = M_IN;
    flag = 1'b0;
    k = 0;
    while (!w_ov[0] && k < 20) begin
      if (w_ir[0]) flag = 1'b1;
      @(negedge clock);
      k++;
    end
    chk("ign ready low in busy", 128'(flag), 128'd0);
    chk("ign latency", 128'(k), 128'd4);
    chk("ign out", w_out[0], V1_OUT);
    tb_in_valid[0] = 1'b0;
    @(negedge clock);
    chk("ign idle", 128'({w_ov[0], w_ir[0]}), 128'b01);
    flag = 1'b0;
    repeat (6) begin @(negedge clock); if (w_ov[0]) flag = 1'b1; end
    chk("ign no second accept", 128'(flag), 128'd0);

    // Back-to-back throughput: period = 4/COLS_PER_CYCLE + 2.
    for (int s = 0; s < 3; s++) begin
      acc = '{-100, -100, -100};
      na = 0;
      tb_in = V1_IN;
      tb_in_valid[s] = 1'b1;
      tb_out_ready[s] = 1'b1;
      for (int t = 0; t < 40 && na < 3; t++) begin
        if (w_ir[s]) begin acc[na] = cyc; na++; end
        @(negedge clock);
      end
      tb_in_valid[s] = 1'b0;
      chk($sformatf("tput dut%0d gap0", s), 128'(acc[1] - acc[0]), 128'((4 >> s) + 2));
      chk($sformatf("tput dut%0d gap1", s), 128'(acc[2] - acc[1]), 128'((4 >> s) + 2));
      k = 0;
      while (!w_ov[s] && k < 20) begin @(negedge clock); k++; end
      chk($sformatf("tput dut%0d out", s), w_out[s], V1_OUT);
      repeat (3) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
